// File: rtl/dram_port_arb.sv
// dram_port_arb: round-robin DRAM port arbiter (vector loader reads vs distance writeback)
// with burst cap, write-to-read turnaround and fixed-latency read valid; DRAM_ARB_STATS_EN adds beat/handover counters.
module dram_port_arb #(
    parameter int ADD_WIDTH  = 20,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rd_req,
    input  logic [ADD_WIDTH-1:0]  rd_add,
    input  logic                  rd_last,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADD_WIDTH-1:0]  wr_add,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  wr_gnt,
    output logic                  dram_en,
    output logic                  dram_we,
    output logic [ADD_WIDTH-1:0]  dram_add,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    output logic                  busy
`ifdef DRAM_ARB_STATS_EN
    ,
    output logic [31:0]           rd_beats,
    output logic [31:0]           wr_beats,
    output logic [15:0]           handover_cnt
`endif
);
    localparam int CW = $clog2(MAX_BURST);

    typedef enum logic [1:0] {IDLE, GNT_RD, GNT_WR, TURN} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     beat_cnt, beat_cnt_nx;
    logic              last_own_wr, last_own_wr_nx;
    logic              last_wr;
    logic [RD_LAT-1:0] vld_sr;
    logic              rd_acc, wr_acc, acc, cap, handover;
    logic              own_req, own_last, oth_req;

    assign rd_acc     = state == GNT_RD && rd_req;
    assign wr_acc     = state == GNT_WR && wr_req;
    assign acc        = rd_acc || wr_acc;
    assign cap        = beat_cnt == CW'(MAX_BURST - 1);
    assign own_req    = state == GNT_WR ? wr_req : rd_req;
    assign own_last   = state == GNT_WR ? wr_last : rd_last;
    assign oth_req    = state == GNT_WR ? rd_req : wr_req;
    assign rd_gnt     = state == GNT_RD;
    assign wr_gnt     = state == GNT_WR;
    assign dram_en    = acc;
    assign dram_we    = wr_acc;
    assign dram_add   = rd_acc ? rd_add : wr_acc ? wr_add : '0;
    assign dram_wdata = acc ? wr_data : '0;
    assign rd_vld     = vld_sr[RD_LAT-1];
    assign rd_data    = dram_rdata;
    assign busy       = state != IDLE || |vld_sr;

    always_comb begin
        state_nx       = state;
        beat_cnt_nx    = beat_cnt;
        last_own_wr_nx = last_own_wr;
        handover       = 1'b0;
        case (state)
            IDLE: begin
                // reads go first on a tie only when writes owned the port last
                if (en && (rd_req || wr_req))
                    state_nx = rd_req && (!wr_req || last_own_wr) ? (last_own_wr && last_wr ? TURN : GNT_RD) : GNT_WR;
            end
            GNT_RD, GNT_WR: begin
                if (!own_req || own_last) begin
                    state_nx       = IDLE;
                    beat_cnt_nx    = '0;
                    last_own_wr_nx = state == GNT_WR;
                end else if (cap && oth_req && en) begin
                    handover       = 1'b1;
                    state_nx       = state == GNT_WR ? TURN : GNT_WR;
                    beat_cnt_nx    = '0;
                    last_own_wr_nx = state == GNT_WR;
                end else begin
                    beat_cnt_nx = cap ? '0 : beat_cnt + CW'(1);
                end
            end
            default: state_nx = GNT_RD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            last_own_wr <= 1'b1;
            last_wr     <= 1'b0;
            vld_sr      <= '0;
        end else begin
            state       <= state_nx;
            beat_cnt    <= beat_cnt_nx;
            last_own_wr <= last_own_wr_nx;
            last_wr     <= acc ? wr_acc : last_wr;
            vld_sr      <= (vld_sr << 1) | RD_LAT'(rd_acc);
        end
    end

`ifdef DRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_beats     <= '0;
            wr_beats     <= '0;
            handover_cnt <= '0;
        end else begin
            rd_beats     <= rd_beats + 32'(rd_acc);
            wr_beats     <= wr_beats + 32'(wr_acc);
            handover_cnt <= handover_cnt + 16'(handover);
        end
    end
`endif
endmodule

// File: tb/tb_dram_port_arb.sv
// tb_dram_port_arb: randomized + directed bench for dram_port_arb against a transaction-level model.
module tb_dram_port_arb;
    localparam int AW = 20, DW = 32, MB = 16, RL = 2;
    localparam int NONE = 0, RD = 1, WR = 2;

    logic          clk = 0, rst = 0, en = 0;
    logic          rd_req = 0, rd_last = 0, wr_req = 0, wr_last = 0;
    logic [AW-1:0] rd_add = '0, wr_add = '0, dram_add;
    logic [DW-1:0] wr_data = '0, dram_rdata = '0, dram_wdata, rd_data;
    logic          rd_gnt, rd_vld, wr_gnt, dram_en, dram_we, busy;
`ifdef DRAM_ARB_STATS_EN
    logic [31:0]   rd_beats, wr_beats;
    logic [15:0]   handover_cnt;
`endif

    always #5 clk = ~clk;

    dram_port_arb #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .en(en),
        .rd_req(rd_req), .rd_add(rd_add), .rd_last(rd_last), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
        .wr_req(wr_req), .wr_add(wr_add), .wr_data(wr_data), .wr_last(wr_last), .wr_gnt(wr_gnt),
        .dram_en(dram_en), .dram_we(dram_we), .dram_add(dram_add), .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata), .busy(busy)
`ifdef DRAM_ARB_STATS_EN
        , .rd_beats(rd_beats), .wr_beats(wr_beats), .handover_cnt(handover_cnt)
`endif
    );

    int n_chk = 0, n_err = 0, cyc = 0;
    int own, last_own, burst, m_rdb, m_wrb, m_ho;
    bit turn, last_wr;
    int vq[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic m_reset();
        own = NONE; turn = 0; last_own = WR; last_wr = 0; burst = 0;
        m_rdb = 0; m_wrb = 0; m_ho = 0;
        vq.delete();
    endtask

    task automatic tick();
        bit ar, aw, v, xr, xl, orq;
        int pick;
        @(negedge clk);
        ar = own == RD && rd_req;
        aw = own == WR && wr_req;
        v  = vq.size() > 0 && vq[0] == cyc;
        check("rd_gnt", rd_gnt, own == RD);
        check("wr_gnt", wr_gnt, own == WR);
        check("dram_en", dram_en, ar || aw);
        check("dram_we", dram_we, aw);
        check("dram_add", dram_add, ar ? rd_add : aw ? wr_add : '0);
        check("dram_wdata", dram_wdata, (ar || aw) ? wr_data : '0);
        check("rd_vld", rd_vld, v);
        check("rd_data", rd_data, dram_rdata);
        check("busy", busy, own != NONE || turn || vq.size() > 0);
`ifdef DRAM_ARB_STATS_EN
        check("rd_beats", rd_beats, m_rdb);
        check("wr_beats", wr_beats, m_wrb);
        check("handover_cnt", handover_cnt, m_ho);
`endif
        if (v) void'(vq.pop_front());
        if (rst) begin
            if (ar) begin vq.push_back(cyc + RL); m_rdb++; end
            if (aw) m_wrb++;
            if (ar || aw) last_wr = aw;
            if (turn) begin
                turn = 0; own = RD; burst = 0;
            end else if (own == NONE) begin
                if (en && (rd_req || wr_req)) begin
                    pick = (rd_req && wr_req) ? (last_own == RD ? WR : RD) : (rd_req ? RD : WR);
                    if (pick == RD && last_own == WR && last_wr) turn = 1;
                    else own = pick;
                end
            end else begin
                xr  = own == RD ? rd_req : wr_req;
                xl  = own == RD ? rd_last : wr_last;
                orq = own == RD ? wr_req : rd_req;
                burst++;
                if (!xr || xl) begin
                    last_own = own; own = NONE; burst = 0;
                end else if (burst % MB == 0 && en && orq) begin
                    m_ho++; last_own = own; burst = 0;
                    if (own == RD) own = WR;
                    else begin own = NONE; turn = 1; end
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        dram_rdata = $urandom;
    endtask

    task automatic do_reset();
        rst = 0; en = 0; rd_req = 0; wr_req = 0; rd_last = 0; wr_last = 0;
        m_reset();
        repeat (2) tick();
        rst = 1;
    endtask

    initial begin
        m_reset();
        @(posedge clk); #1;
        do_reset();
        en = 1;
        // four-beat read at addresses 3..6, then drain
        rd_req = 1;
        for (int i = 0; i < 5; i++) begin
            rd_add  = AW'(i == 0 ? 3 : i + 2);
            rd_last = i == 4;
            tick();
        end
        rd_req = 0; rd_last = 0;
        repeat (4) tick();
        // simultaneous rise from reset, then read-after-write turnaround
        do_reset(); en = 1;
        rd_req = 1; wr_req = 1; wr_add = 20'h1234; wr_data = 32'hCAFE0001;
        for (int i = 0; i < 14; i++) begin
            rd_last = i == 3;
            wr_last = i == 7;
            if (i == 4) rd_req = 0;
            if (i == 8) begin wr_req = 0; rd_req = 1; end
            if (i == 12) rd_last = 1;
            tick();
        end
        rd_req = 0; rd_last = 0; wr_last = 0;
        repeat (3) tick();
        // burst cap: continuous reads, write arrives at beat 5
        do_reset(); en = 1;
        rd_req = 1;
        for (int i = 0; i < 24; i++) begin
            if (i == 5) wr_req = 1;
            rd_add = AW'($urandom); wr_add = AW'($urandom); wr_data = $urandom;
            tick();
        end
        wr_last = 1; tick(); wr_last = 0; wr_req = 0;
        repeat (20) tick();
        // read alone for 40+ beats, cap wraps without handover
        do_reset(); en = 1;
        rd_req = 1; wr_req = 0;
        repeat (42) tick();
        rd_req = 0; repeat (4) tick();
        // async reset in the middle of a write burst
        do_reset(); en = 1;
        wr_req = 1;
        repeat (3) tick();
        #2 rst = 0;
        #1 check("async_rst", {rd_gnt, wr_gnt, dram_en, dram_we, rd_vld, busy}, 6'd0);
        m_reset();
        wr_req = 0;
        tick();
        rst = 1; en = 1; rd_req = 1; wr_req = 1;
        for (int i = 0; i < 4; i++) begin
            rd_last = i == 2;
            tick();
        end
        rd_req = 0; rd_last = 0; wr_last = 1; tick(); wr_last = 0; wr_req = 0;
        repeat (4) tick();
        // randomized traffic with varying burst lengths
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 800; i++) begin
                en      = $urandom_range(0, 15) != 0;
                rd_req  = $urandom_range(0, 9) == 0 ? ~rd_req : rd_req;
                wr_req  = $urandom_range(0, 9) == 0 ? ~wr_req : wr_req;
                rd_last = seg < 3 && $urandom_range(0, seg * 12 + 3) == 0;
                wr_last = seg < 3 && $urandom_range(0, seg * 12 + 3) == 0;
                rd_add  = AW'($urandom); wr_add = AW'($urandom); wr_data = $urandom;
                tick();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
